mm2st_stream_arbiter: RTL

Packet-granular round-robin arbiter that shares one 16-bit Avalon-ST source between two MM-to-ST sink channels in the acquisition path. It locks the output to one channel from startofpacket to endofpacket and enforces a maximum packet length. It drops words that arrive outside a packet. It drives the shared source port directly with zero-latency passthrough once a grant is held.

---
 rtl/mm2st_stream_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mm2st_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST source between two sink channels.
// Optional per-channel packet counters are enabled with the MM2ST_ARB_PKT_CNT_EN macro.
module mm2st_stream_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_PKT_LEN = 1024
) (
    input  logic                  avalon_st_clk,
    input  logic                  avalon_st_reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] ch0_sink_data,
    input  logic                  ch0_sink_valid,
    input  logic                  ch0_sink_startofpacket,
    input  logic                  ch0_sink_endofpacket,
    output logic                  ch0_sink_ready,
    input  logic [DATA_WIDTH-1:0] ch1_sink_data,
    input  logic                  ch1_sink_valid,
    input  logic                  ch1_sink_startofpacket,
    input  logic                  ch1_sink_endofpacket,
    output logic                  ch1_sink_ready,
    output logic [DATA_WIDTH-1:0] avalon_st_source_data,
    output logic                  avalon_st_source_valid,
    output logic                  avalon_st_source_startofpacket,
    output logic                  avalon_st_source_endofpacket,
    input  logic                  avalon_st_source_ready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  err_truncate,
    output logic                  err_orphan
`ifdef MM2ST_ARB_PKT_CNT_EN
    ,
    output logic [15:0]           ch0_pkt_count,
    output logic [15:0]           ch1_pkt_count
`endif
);

    localparam logic [15:0] LAST_IDX = 16'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN
    } state_t;

    state_t      state_reg;
    logic        owner_reg;
    logic        last_grant_reg;
    logic [15:0] word_cnt_reg;
    logic [1:0]  grant_reg;
    logic        busy_reg;
    logic        err_truncate_reg;
    logic        err_orphan_reg;

    logic [DATA_WIDTH-1:0] sink_data [2];
    logic [1:0] sink_valid;
    logic [1:0] sink_sop;
    logic [1:0] sink_eop;
    logic [1:0] sink_ready;
    logic [1:0] req;
    logic [1:0] orphan;

    logic own_valid;
    logic own_sop;
    logic own_eop;
    logic trunc_hit;
    logic src_beat;
    logic drain_eop;
    logic pick;

    assign sink_data[0] = ch0_sink_data;
    assign sink_data[1] = ch1_sink_data;
    assign sink_valid   = {ch1_sink_valid, ch0_sink_valid};
    assign sink_sop     = {ch1_sink_startofpacket, ch0_sink_startofpacket};
    assign sink_eop     = {ch1_sink_endofpacket, ch0_sink_endofpacket};
    assign ch0_sink_ready = sink_ready[0];
    assign ch1_sink_ready = sink_ready[1];

    assign req    = sink_valid & sink_sop;
    assign orphan = sink_valid & ~sink_sop;

    assign own_valid = sink_valid[owner_reg];
    assign own_sop   = sink_sop[owner_reg];
    assign own_eop   = sink_eop[owner_reg];
    assign trunc_hit = (word_cnt_reg == LAST_IDX);
    assign src_beat  = (state_reg == ST_GRANT) && own_valid && avalon_st_source_ready;
    assign drain_eop = (state_reg == ST_DRAIN) && own_valid && own_eop;

    // On a tie the channel that did not win last time is served.
    assign pick = (req[0] && req[1]) ? ~last_grant_reg : req[1];

    always_comb begin
        avalon_st_source_data          = '0;
        avalon_st_source_valid         = 1'b0;
        avalon_st_source_startofpacket = 1'b0;
        avalon_st_source_endofpacket   = 1'b0;
        sink_ready                     = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                sink_ready = orphan;
            end
            ST_GRANT: begin
                avalon_st_source_data          = sink_data[owner_reg];
                avalon_st_source_valid         = own_valid;
                avalon_st_source_startofpacket = own_sop;
                avalon_st_source_endofpacket   = own_eop | trunc_hit;
                sink_ready[owner_reg]          = avalon_st_source_ready;
            end
            ST_DRAIN: begin
                sink_ready[owner_reg] = 1'b1;
            end
            default: begin
                sink_ready = 2'b00;
            end
        endcase
    end

    always_ff @(posedge avalon_st_clk) begin
        if (avalon_st_reset) begin
            state_reg        <= ST_IDLE;
            owner_reg        <= 1'b0;
            last_grant_reg   <= 1'b1;
            word_cnt_reg     <= '0;
            grant_reg        <= 2'b00;
            busy_reg         <= 1'b0;
            err_truncate_reg <= 1'b0;
            err_orphan_reg   <= 1'b0;
        end else begin
            err_truncate_reg <= 1'b0;
            err_orphan_reg   <= (state_reg == ST_IDLE) && (|orphan);
            case (state_reg)
                ST_IDLE: begin
                    if (enable && (|req)) begin
                        state_reg    <= ST_GRANT;
                        owner_reg    <= pick;
                        grant_reg    <= pick ? 2'b10 : 2'b01;
                        busy_reg     <= 1'b1;
                        word_cnt_reg <= '0;
                    end
                end
                ST_GRANT: begin
                    if (src_beat) begin
                        if (own_eop) begin
                            state_reg      <= ST_IDLE;
                            last_grant_reg <= owner_reg;
                            word_cnt_reg   <= '0;
                            grant_reg      <= 2'b00;
                            busy_reg       <= 1'b0;
                        end else if (trunc_hit) begin
                            state_reg        <= ST_DRAIN;
                            err_truncate_reg <= 1'b1;
                            word_cnt_reg     <= '0;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_eop) begin
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= owner_reg;
                        grant_reg      <= 2'b00;
                        busy_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant        = grant_reg;
    assign busy         = busy_reg;
    assign err_truncate = err_truncate_reg;
    assign err_orphan   = err_orphan_reg;

`ifdef MM2ST_ARB_PKT_CNT_EN
    // A packet is counted on its real eop beat, whether passed through or drained.
    logic        pkt_done;
    logic [15:0] pkt_count_reg [2];

    assign pkt_done = (src_beat && own_eop) || drain_eop;

    for (genvar gi = 0; gi < 2; gi++) begin : g_pkt_cnt
        always_ff @(posedge avalon_st_clk) begin
            if (avalon_st_reset) begin
                pkt_count_reg[gi] <= '0;
            end else if (pkt_done && (owner_reg == 1'(gi))) begin
                pkt_count_reg[gi] <= pkt_count_reg[gi] + 16'd1;
            end
        end
    end

    assign ch0_pkt_count = pkt_count_reg[0];
    assign ch1_pkt_count = pkt_count_reg[1];
`endif

endmodule
